// File: rtl/mips_enc_pkg.sv
// ============================================================================
// mips_enc_pkg : class codes, opcode/funct constants and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_enc_pkg;

  typedef enum logic [2:0] {
    CLS_ADD = 3'd0,
    CLS_SUB = 3'd1,
    CLS_AND = 3'd2,
    CLS_OR  = 3'd3,
    CLS_SLT = 3'd4,
    CLS_LW  = 3'd5,
    CLS_SW  = 3'd6,
    CLS_BEQ = 3'd7
  } req_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/mips_instr_pack.sv
// ============================================================================
// mips_instr_pack : combinational assembly of a MIPS word from class + fields
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_instr_pack
  import mips_enc_pkg::*;
(
  input  logic [2:0]  class_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o
);

  req_class_e w_class;
  logic [5:0] w_funct;
  logic [5:0] w_opcode;
  logic       w_rtype;

  assign w_class = req_class_e'(class_i);

  always_comb begin
    w_rtype  = 1'b1;
    w_opcode = OP_RTYPE;
    w_funct  = FN_ADD;
    case (w_class)
      CLS_ADD: w_funct = FN_ADD;
      CLS_SUB: w_funct = FN_SUB;
      CLS_AND: w_funct = FN_AND;
      CLS_OR:  w_funct = FN_OR;
      CLS_SLT: w_funct = FN_SLT;
      CLS_LW:  begin w_rtype = 1'b0; w_opcode = OP_LW;  end
      CLS_SW:  begin w_rtype = 1'b0; w_opcode = OP_SW;  end
      CLS_BEQ: begin w_rtype = 1'b0; w_opcode = OP_BEQ; end
      default: w_funct = FN_ADD;
    endcase
  end

  // R-type ignores the immediate; I-type ignores rd
  assign word_o = w_rtype ? {w_opcode, rs_i, rt_i, rd_i, 5'b00000, w_funct}
                          : {w_opcode, rs_i, rt_i, imm_i};

endmodule

`default_nettype wire

// File: rtl/mips_instr_encoder.sv
// ============================================================================
// mips_instr_encoder : accepts an instruction request, latches the encoded
// word and streams it out as four bytes. Rev 1.0
// ============================================================================
`default_nettype none

module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int COUNT_W   = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_class,
  input  logic [4:0]         req_rs,
  input  logic [4:0]         req_rt,
  input  logic [4:0]         req_rd,
  input  logic [15:0]        req_imm,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic [31:0]        instr_word,
  output logic [COUNT_W-1:0] instr_count
);

  enc_state_e         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [31:0]        word_q, word_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        w_packed;
  logic [1:0]         w_byte_sel;

  mips_instr_pack u_pack (
    .class_i (req_class),
    .rs_i    (req_rs),
    .rt_i    (req_rt),
    .rd_i    (req_rd),
    .imm_i   (req_imm),
    .word_o  (w_packed)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_byte_sel = ~idx_q;
    end else begin : g_lsb_first
      assign w_byte_sel = idx_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          word_d  = w_packed;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            count_d = count_q + COUNT_W'(1);
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    tx_data = word_q[7:0];
    case (w_byte_sel)
      2'd0: tx_data = word_q[7:0];
      2'd1: tx_data = word_q[15:8];
      2'd2: tx_data = word_q[23:16];
      2'd3: tx_data = word_q[31:24];
      default: tx_data = word_q[7:0];
    endcase
  end

  // Handshake outputs come straight from the state register
  assign req_ready   = (state_q == ST_IDLE);
  assign tx_valid    = (state_q == ST_SEND);
  assign tx_last     = (state_q == ST_SEND) && (idx_q == 2'd3);
  assign instr_word  = word_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire
